multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style multicycle control unit sitting directly upstream of the 16-bit datapath.
- Sequences fetch, decode, execute, memory and write-back states.
- Drives every datapath control line and exports current_state/next_state for debug.
- Holds in memory states until the memory handshake completes, and counts retired instructions.

Parameters:
STATE_W, 5, width of state encoding
CNT_W, 16, width of retired-instruction counter

Ports:
CLK  input  1  system clock, rising-edge
RST_N  input  1  asynchronous active-low reset
Opcode  input  4  IROut[15:12] from the instruction register
Zero  input  1  ALU zero flag from the current cycle
MemReady  input  1  memory handshake; access completes in the cycle it is 1
current_state  output  STATE_W  registered state
next_state  output  STATE_W  combinational next state
PCWrite  output  1  PC load enable, final value including branch condition
IorD  output  1  0 = PC address, 1 = ALUOut address
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  IR load enable
RegDst  output  1  0 = rt, 1 = rd write address
MemtoReg  output  1  0 = ALUOut, 1 = MDR write data
GRegWrite  output  1  register file write enable
ALUSrcA  output  1  0 = PC, 1 = A register
ALUSrcB  output  2  0 = B, 1 = constant 1, 2 = sign-extended imm, 3 = sign-extended imm (branch offset)
ALUOp  output  3  0 = add, 1 = sub, 2 = funct-decoded
PCSource  output  2  0 = ALU, 1 = ALUOut, 2 = jump target
Halted  output  1  high in HALT
InstrCount  output  CNT_W  retired-instruction count

Behaviour:
- Reset (RST_N=0, asynchronous): current_state=FETCH(0) and InstrCount=0 immediately. Outputs take FETCH decode values.
- Reset mid-instruction aborts the instruction with no further writes after reset asserts.
- State encoding:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5
  - R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, HALT=12
  - Unused codes 13-31 go to FETCH.
- Opcodes: 0=R-type, 1=addi, 2=lw, 3=sw, 4=beq, 5=bne, 6=j, F=halt. Others are illegal and execute as NOP (DECODE->FETCH).
- FETCH: MemRead=1, IorD=0, IRWrite=MemReady, ALUSrcA=0, ALUSrcB=1, ALUOp=add, PCSource=0, PCWrite=MemReady. Stays in FETCH while MemReady=0, else -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=add (branch target precompute). Dispatches on Opcode: 0->R_EXEC, 1->I_EXEC, 2/3->MEM_ADDR, 4/5->BRANCH, 6->JUMP, F->HALT, else->FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=add. Opcode 2->MEM_READ, 3->MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Holds until MemReady, then -> MEM_WB.
- MEM_WB: GRegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Holds until MemReady, then -> FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2 -> R_WB.
- R_WB: GRegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=2, ALUOp=add -> I_WB.
- I_WB: GRegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=sub, PCSource=1. PCWrite=Zero for beq, ~Zero for bne -> FETCH.
- JUMP: PCSource=2, PCWrite=1 -> FETCH.
- HALT: Halted=1, all write enables 0. Stays until reset.
- Any signal not listed for a state is 0.
- MemRead and MemWrite are never both 1.
- InstrCount increments by 1 on each transition into FETCH from a non-FETCH, non-reset state (including illegal-opcode NOP). Wraps 0xFFFF->0. Never increments in HALT or while stalled.
- Latency (cycles, MemReady always 1): R-type 4, addi 4, lw 5, sw 4, beq/bne 3, j 3.

Test Plan:
- Reset: RST_N low mid-R_EXEC between clock edges -> current_state=0 and InstrCount=0 before the next edge; PCWrite=0 while MemReady=0.
- R-type: Opcode=0, MemReady=1 -> states 0,1,6,7,0. GRegWrite=1 and RegDst=1 only in state 7. InstrCount 0->1.
- lw with stall: Opcode=2, MemReady=0 for 3 cycles in MEM_READ -> state 3 held 3 cycles with MemRead=1, IorD=1. Then 4 with MemtoReg=1, GRegWrite=1. Total 8 cycles.
- Branch:
  - beq with Zero=1 -> PCWrite=1, PCSource=1 in state 8.
  - bne with Zero=1 -> PCWrite=0.
  - Both return to FETCH; InstrCount +1 each.
- Halt/illegal:
  - Opcode=7 -> 0,1,0 with InstrCount +1.
  - Opcode=F -> state 12 held 10 cycles, Halted=1, InstrCount frozen.
- Wrap: preload InstrCount to 0xFFFF via 65535 jumps (Opcode=6) -> next retire gives 0x0000.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore multicycle control unit for the 16-bit datapath
//
// Ports:
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   Opcode, Zero          IR[15:12] and ALU zero flag
//   MemReady              memory access completes in the cycle it is high
//   current_state         registered state, next_state combinational next state
//   PCWrite..PCSource     datapath control lines (Moore decode of current_state)
//   Halted                high while parked in HALT
//   InstrCount            retired-instruction counter, wraps

module multicycle_control #(
    parameter int STATE_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [3:0]         Opcode,
    input  logic               Zero,
    input  logic               MemReady,
    output logic [STATE_W-1:0] current_state,
    output logic [STATE_W-1:0] next_state,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               GRegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               Halted,
    output logic [CNT_W-1:0]   InstrCount
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = STATE_W'(0),
        S_DECODE    = STATE_W'(1),
        S_MEM_ADDR  = STATE_W'(2),
        S_MEM_READ  = STATE_W'(3),
        S_MEM_WB    = STATE_W'(4),
        S_MEM_WRITE = STATE_W'(5),
        S_R_EXEC    = STATE_W'(6),
        S_R_WB      = STATE_W'(7),
        S_BRANCH    = STATE_W'(8),
        S_JUMP      = STATE_W'(9),
        S_I_EXEC    = STATE_W'(10),
        S_I_WB      = STATE_W'(11),
        S_HALT      = STATE_W'(12)
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;
    localparam logic [3:0] OP_J     = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  count_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // An instruction retires on any entry into FETCH from a non-FETCH state;
    // HALT never reaches FETCH and FETCH stalls are FETCH->FETCH.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
        end else if (state_d == S_FETCH && state_q != S_FETCH) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:      state_d = S_R_EXEC;
                    OP_ADDI:       state_d = S_I_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_HALT:       state_d = S_HALT;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (Opcode == OP_LW) begin
                    state_d = S_MEM_READ;
                end else if (Opcode == OP_SW) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_READ:  state_d = MemReady ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = MemReady ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_I_EXEC:    state_d = S_I_WB;
            S_I_WB:      state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        GRegWrite = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'd0;
        ALUOp     = ALU_ADD;
        PCSource  = 2'd0;
        Halted    = 1'b0;
        case (state_q)
            S_FETCH: begin
                // PC+1 and IR load only commit in the cycle memory delivers.
                MemRead = 1'b1;
                IRWrite = MemReady;
                ALUSrcB = 2'd1;
                PCWrite = MemReady;
            end
            S_DECODE: begin
                // Branch target precomputed while the opcode is being decoded.
                ALUSrcB = 2'd3;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                GRegWrite = 1'b1;
                MemtoReg  = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            S_R_WB: begin
                GRegWrite = 1'b1;
                RegDst    = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALU_SUB;
                PCSource = 2'd1;
                if (Opcode == OP_BEQ) begin
                    PCWrite = Zero;
                end else if (Opcode == OP_BNE) begin
                    PCWrite = ~Zero;
                end
            end
            S_JUMP: begin
                PCSource = 2'd2;
                PCWrite  = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
            end
            S_I_WB: begin
                GRegWrite = 1'b1;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign current_state = state_q;
    assign next_state    = state_d;
    assign InstrCount    = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized model-checked bench for multicycle_control

module tb_multicycle_control;

    typedef int iq_t[$];

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] Opcode = 4'h0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;

    logic [4:0]  current_state, next_state;
    logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, GRegWrite;
    logic        ALUSrcA, Halted;
    logic [1:0]  ALUSrcB, PCSource;
    logic [2:0]  ALUOp;
    logic [15:0] InstrCount;

    logic [4:0]  s_current_state, s_next_state;
    logic        s_PCWrite, s_IorD, s_MemRead, s_MemWrite, s_IRWrite, s_RegDst, s_MemtoReg, s_GRegWrite;
    logic        s_ALUSrcA, s_Halted;
    logic [1:0]  s_ALUSrcB, s_PCSource;
    logic [2:0]  s_ALUOp;
    logic [3:0]  s_InstrCount;

    multicycle_control u_dut (
        .CLK(CLK), .RST_N(RST_N), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .current_state(current_state), .next_state(next_state),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .GRegWrite(GRegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .Halted(Halted), .InstrCount(InstrCount)
    );

    // Narrow counter instance so counter wrap-around is reachable in a short run.
    multicycle_control #(.STATE_W(5), .CNT_W(4)) u_small (
        .CLK(CLK), .RST_N(RST_N), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .current_state(s_current_state), .next_state(s_next_state),
        .PCWrite(s_PCWrite), .IorD(s_IorD), .MemRead(s_MemRead), .MemWrite(s_MemWrite),
        .IRWrite(s_IRWrite), .RegDst(s_RegDst), .MemtoReg(s_MemtoReg), .GRegWrite(s_GRegWrite),
        .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB), .ALUOp(s_ALUOp), .PCSource(s_PCSource),
        .Halted(s_Halted), .InstrCount(s_InstrCount)
    );

    always #5 CLK = ~CLK;

    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b0;

    int  m_state = 0;
    iq_t m_rest;
    int  m_cnt = 0;

    // States an instruction walks through after DECODE.
    function automatic iq_t path_of(int op);
        iq_t q;
        case (op)
            0:       begin q.push_back(6); q.push_back(7); end
            1:       begin q.push_back(10); q.push_back(11); end
            2:       begin q.push_back(2); q.push_back(3); q.push_back(4); end
            3:       begin q.push_back(2); q.push_back(5); end
            4, 5:    q.push_back(8);
            6:       q.push_back(9);
            15:      q.push_back(12);
            default: ;
        endcase
        return q;
    endfunction

    function automatic int model_next();
        iq_t p;
        case (m_state)
            0:    return MemReady ? 1 : 0;
            1: begin
                p = path_of(int'(Opcode));
                return (p.size() > 0) ? p[0] : 0;
            end
            3, 5: begin
                if (!MemReady) return m_state;
            end
            12:   return 12;
            default: ;
        endcase
        return (m_rest.size() > 0) ? m_rest[0] : 0;
    endfunction

    // {PCWrite,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,GRegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,Halted}
    function automatic logic [16:0] exp_ctrl(int st, logic mr, logic z, int op);
        logic pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca, hlt;
        logic [1:0] srcb, pcs;
        logic [2:0] aop;
        {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca, hlt} = '0;
        srcb = 2'd0; pcs = 2'd0; aop = 3'd0;
        case (st)
            0:  begin mrd = 1; irw = mr; srcb = 2'd1; pcw = mr; end
            1:  srcb = 2'd3;
            2:  begin srca = 1; srcb = 2'd2; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 3'd2; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin
                srca = 1; aop = 3'd1; pcs = 2'd1;
                pcw = (op == 4) ? z : ((op == 5) ? ~z : 1'b0);
            end
            9:  begin pcs = 2'd2; pcw = 1; end
            10: begin srca = 1; srcb = 2'd2; end
            11: rw = 1;
            12: hlt = 1;
            default: ;
        endcase
        return {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aop, pcs, hlt};
    endfunction

    // Reference model update.
    initial begin
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                m_state = 0;
                m_rest.delete();
                m_cnt = 0;
            end else begin
                int nxt;
                nxt = model_next();
                if (m_state == 1) m_rest = path_of(int'(Opcode));
                if (m_state != 0 && m_state != 12 && nxt != m_state && m_rest.size() > 0)
                    void'(m_rest.pop_front());
                if (nxt == 0 && m_state != 0) m_cnt++;
                m_state = nxt;
            end
        end
    end

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            cmp("state", 32'(current_state), 32'(m_state));
            cmp("next_state", 32'(next_state), 32'(model_next()));
            cmp("ctrl", 32'({PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, GRegWrite,
                             ALUSrcA, ALUSrcB, ALUOp, PCSource, Halted}),
                32'(exp_ctrl(m_state, MemReady, Zero, int'(Opcode))));
            cmp("count", 32'(InstrCount), 32'(m_cnt & 16'hFFFF));
            cmp("small_state", 32'(s_current_state), 32'(m_state));
            cmp("small_count", 32'(s_InstrCount), 32'(m_cnt % 16));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        step();
        step();
        RST_N = 1'b1;
    endtask

    int halt_cycles;
    int r;

    initial begin
        do_reset();
        chk_en = 1'b1;
        cmp("reset_state", 32'(current_state), 0);
        cmp("reset_count", 32'(InstrCount), 0);

        // R-type: 0,1,6,7,0
        Opcode = 4'h0; MemReady = 1'b1; Zero = 1'b0;
        #1;
        cmp("rt_s0", 32'(current_state), 0);
        step(); cmp("rt_s1", 32'(current_state), 1);
        step(); cmp("rt_s6", 32'(current_state), 6);
        cmp("rt_s6_rw", 32'(GRegWrite), 0);
        step(); cmp("rt_s7", 32'(current_state), 7);
        cmp("rt_s7_rw", 32'(GRegWrite), 1);
        cmp("rt_s7_rdst", 32'(RegDst), 1);
        step(); cmp("rt_done", 32'(current_state), 0);
        cmp("rt_count", 32'(InstrCount), 1);

        // lw with three stall cycles in MEM_READ
        Opcode = 4'h2;
        step(); step(); step();
        MemReady = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            cmp("lw_hold", 32'(current_state), 3);
            cmp("lw_memread", 32'(MemRead), 1);
            cmp("lw_iord", 32'(IorD), 1);
            step();
        end
        cmp("lw_still3", 32'(current_state), 3);
        MemReady = 1'b1;
        step(); cmp("lw_s4", 32'(current_state), 4);
        cmp("lw_m2r", 32'(MemtoReg), 1);
        cmp("lw_rw", 32'(GRegWrite), 1);
        step(); cmp("lw_done", 32'(current_state), 0);
        cmp("lw_count", 32'(InstrCount), 2);

        // beq taken, bne not taken with Zero=1
        Opcode = 4'h4;
        step(); step(); Zero = 1'b1; #1;
        cmp("beq_s8", 32'(current_state), 8);
        cmp("beq_pcw", 32'(PCWrite), 1);
        cmp("beq_pcs", 32'(PCSource), 1);
        step(); cmp("beq_count", 32'(InstrCount), 3);
        Opcode = 4'h5;
        step(); step();
        cmp("bne_pcw", 32'(PCWrite), 0);
        step(); cmp("bne_done", 32'(current_state), 0);
        cmp("bne_count", 32'(InstrCount), 4);

        // Illegal opcode acts as NOP
        Opcode = 4'h7;
        step(); cmp("nop_s1", 32'(current_state), 1);
        step(); cmp("nop_s0", 32'(current_state), 0);
        cmp("nop_count", 32'(InstrCount), 5);

        // Halt holds with counter frozen
        Opcode = 4'hF;
        step(); step();
        for (int i = 0; i < 10; i++) begin
            cmp("halt_state", 32'(current_state), 12);
            cmp("halt_flag", 32'(Halted), 1);
            cmp("halt_count", 32'(InstrCount), 5);
            step();
        end

        // Asynchronous reset in the middle of R_EXEC
        do_reset();
        Opcode = 4'h0; MemReady = 1'b1;
        step(); step();
        cmp("mid_rexec", 32'(current_state), 6);
        #2;
        MemReady = 1'b0;
        RST_N = 1'b0;
        #1;
        cmp("arst_state", 32'(current_state), 0);
        cmp("arst_count", 32'(InstrCount), 0);
        cmp("arst_pcw", 32'(PCWrite), 0);
        step();
        RST_N = 1'b1;

        // Counter wrap on the narrow instance: 16 jumps
        Opcode = 4'h6; MemReady = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step(); step(); step();
        end
        cmp("wrap_pre", 32'(s_InstrCount), 15);
        step(); step(); step();
        cmp("wrap_small", 32'(s_InstrCount), 0);
        cmp("wrap_big", 32'(InstrCount), 16);

        // Randomized traffic
        halt_cycles = 0;
        for (int n = 0; n < 4000; n++) begin
            if (m_state == 0) begin
                r = $urandom_range(0, 39);
                if (r < 35)       Opcode = 4'(r % 7);
                else if (r < 39)  Opcode = 4'(7 + (r - 35));
                else              Opcode = 4'hF;
            end
            MemReady = ($urandom_range(0, 3) != 0);
            Zero = 1'($urandom_range(0, 1));
            if (m_state == 12) begin
                halt_cycles++;
                if (halt_cycles > 3) begin
                    halt_cycles = 0;
                    #1;
                    RST_N = 1'b0;
                    step();
                    RST_N = 1'b1;
                end
            end
            step();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
